// File: rtl/ga_sync_pkg.sv
// -----------------------------------------------------------------------------
// ga_sync_pkg
// Shared constants and types for the gate-array sync / raster-interrupt block.
//   GA_INT_LINES      : lines per raster interrupt (52 -> 300 Hz at 15.6 kHz)
//   GA_INT_VS_THRESH  : minimum line count for an interrupt at vertical sync
//   GA_*_DEF          : default monitor sync delay / width values
//   ga_mode_t         : 2-bit screen mode
//   ga_sat_inc4       : 4-bit saturating increment used by the HSYNC delay
// -----------------------------------------------------------------------------
package ga_sync_pkg;

   localparam logic [5:0] GA_INT_LINES     = 6'd52;
   localparam logic [5:0] GA_INT_VS_THRESH = 6'd32;

   localparam int unsigned GA_HS_DELAY_DEF = 32'd2;
   localparam int unsigned GA_HS_WIDTH_DEF = 32'd4;
   localparam int unsigned GA_VS_DELAY_DEF = 32'd2;
   localparam int unsigned GA_VS_WIDTH_DEF = 32'd4;

   typedef enum logic [1:0] {
      MODE0 = 2'd0,
      MODE1 = 2'd1,
      MODE2 = 2'd2,
      MODE3 = 2'd3
   } ga_mode_t;

   // Increment that sticks at 15 so the delay counter never wraps.
   function automatic logic [3:0] ga_sat_inc4(input logic [3:0] v);
      ga_sat_inc4 = (v == 4'hF) ? 4'hF : (v + 4'd1);
   endfunction

endpackage

// File: rtl/ga_edge_sync.sv
// -----------------------------------------------------------------------------
// ga_edge_sync
// CLKEN-gated sampler for one CRTC sync line plus rise/fall detection.
// The edge strobes are only asserted on a CLKEN cycle.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset
//   i_clken  : character-rate enable
//   i_sig    : CRTC sync input
//   o_rise   : i_sig high while the sampled copy is low (CLKEN cycle)
//   o_fall   : i_sig low while the sampled copy is high (CLKEN cycle)
// -----------------------------------------------------------------------------
module ga_edge_sync
   import ga_sync_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clken,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic r_q;

   // Sample the sync line once per character tick.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= 1'b0;
      end else if (i_clken) begin
         r_q <= i_sig;
      end else begin
         r_q <= r_q;
      end
   end

   assign o_rise = i_clken &  i_sig & ~r_q;
   assign o_fall = i_clken & ~i_sig &  r_q;

endmodule

// File: rtl/ga_sync.sv
// -----------------------------------------------------------------------------
// ga_sync
// Gate-array sync and raster-interrupt block. Consumes the CRTC character-rate
// HSYNC/VSYNC and produces delayed, width-limited monitor syncs, the 52-line
// Z80 raster interrupt and the per-line screen mode.
//
// Ports:
//   CLOCK       system clock
//   RESET       synchronous active-high reset (not CLKEN-gated)
//   CLKEN       character-rate enable shared with the CRTC
//   CRTC_HSYNC  CRTC horizontal sync
//   CRTC_VSYNC  CRTC vertical sync
//   INT_ACK     one-clock Z80 interrupt acknowledge
//   INT_CLR     one-clock RMR write with bit 4 set
//   MODE_IN     screen mode from RMR
//   HSYNC       monitor horizontal sync (registered)
//   VSYNC       monitor vertical sync (registered)
//   INT         Z80 interrupt request, level (registered)
//   MODE        effective screen mode
//   LINE_CNT    interrupt line counter (registered)
//
// Build option GA_MODE_LATCH_EN: when defined MODE is captured from MODE_IN on
// the clock where HSYNC rises; otherwise MODE follows MODE_IN directly.
// -----------------------------------------------------------------------------
module ga_sync
   import ga_sync_pkg::*;
#(
   parameter int unsigned HS_DELAY = GA_HS_DELAY_DEF,
   parameter int unsigned HS_WIDTH = GA_HS_WIDTH_DEF,
   parameter int unsigned VS_DELAY = GA_VS_DELAY_DEF,
   parameter int unsigned VS_WIDTH = GA_VS_WIDTH_DEF
)(
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       CLKEN,
   input  logic       CRTC_HSYNC,
   input  logic       CRTC_VSYNC,
   input  logic       INT_ACK,
   input  logic       INT_CLR,
   input  logic [1:0] MODE_IN,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       INT,
   output logic [1:0] MODE,
   output logic [5:0] LINE_CNT
);

   localparam logic [3:0] L_HS_ON  = 4'(HS_DELAY);
   localparam logic [3:0] L_HS_OFF = 4'(HS_DELAY + HS_WIDTH);
   localparam logic [2:0] L_VS_ON  = 3'(VS_DELAY);
   localparam logic [2:0] L_VS_OFF = 3'(VS_DELAY + VS_WIDTH);

   logic       w_hs_rise, w_hs_fall;
   logic       w_vs_rise, w_vs_fall;

   logic [3:0] r_hdly;
   logic [3:0] w_hdly_inc;
   logic       w_hs_on, w_hs_off;
   logic       r_hsync;

   logic       r_armed;
   logic [2:0] r_vcnt;
   logic [2:0] w_vcnt_inc;
   logic       w_vs_adv, w_vs_int;
   logic       r_vsync;

   logic [5:0] r_line_cnt;
   logic [5:0] w_cnt_inc;
   logic [5:0] w_cnt_ev;
   logic       w_int_set;
   logic       r_int;

   ga_edge_sync u_hs_edge (
      .i_clk   (CLOCK),
      .i_rst   (RESET),
      .i_clken (CLKEN),
      .i_sig   (CRTC_HSYNC),
      .o_rise  (w_hs_rise),
      .o_fall  (w_hs_fall)
   );

   ga_edge_sync u_vs_edge (
      .i_clk   (CLOCK),
      .i_rst   (RESET),
      .i_clken (CLKEN),
      .i_sig   (CRTC_VSYNC),
      .o_rise  (w_vs_rise),
      .o_fall  (w_vs_fall)
   );

   // ---------------------------------------------------------------- horizontal
   assign w_hdly_inc = ga_sat_inc4(r_hdly);

   // "Reaches" means the counter steps onto the value, so a saturated counter
   // sitting at 15 never re-fires a threshold.
   assign w_hs_on  = CLKEN & CRTC_HSYNC & ~w_hs_rise &
                     (r_hdly != L_HS_ON) & (w_hdly_inc == L_HS_ON);
   assign w_hs_off = (CLKEN & ~w_hs_rise &
                      (r_hdly != L_HS_OFF) & (w_hdly_inc == L_HS_OFF)) | w_hs_fall;

   // Delay counter: restarts at each CRTC HSYNC rise, idles saturated at 15.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_hdly <= 4'hF;
      end else if (w_hs_rise) begin
         r_hdly <= 4'h0;
      end else if (CLKEN) begin
         r_hdly <= w_hdly_inc;
      end else begin
         r_hdly <= r_hdly;
      end
   end

   // Monitor HSYNC: end of width or CRTC fall wins over the start condition.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_hsync <= 1'b0;
      end else if (w_hs_off) begin
         r_hsync <= 1'b0;
      end else if (w_hs_on) begin
         r_hsync <= 1'b1;
      end else begin
         r_hsync <= r_hsync;
      end
   end

   // ------------------------------------------------------------------ vertical
   assign w_vcnt_inc = r_vcnt + 3'd1;
   // While armed the sampled VSYNC is high, so a vs_fall is the "sampled low"
   // end condition; it suppresses any HSYNC fall counted in the same tick.
   assign w_vs_adv   = w_hs_fall & r_armed & ~w_vs_fall & ~w_vs_rise;
   assign w_vs_int   = w_vs_adv & (w_vcnt_inc == L_VS_ON);

   // Armed window: counts CRTC HSYNC falls after a VSYNC rise.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_armed <= 1'b0;
         r_vcnt  <= 3'd0;
         r_vsync <= 1'b0;
      end else if (w_vs_rise) begin
         r_armed <= 1'b1;
         r_vcnt  <= 3'd0;
         r_vsync <= 1'b0;
      end else if (r_armed & w_vs_fall) begin
         r_armed <= 1'b0;
         r_vsync <= 1'b0;
      end else if (w_vs_adv) begin
         r_vcnt <= w_vcnt_inc;
         if (w_vcnt_inc == L_VS_ON) begin
            r_vsync <= 1'b1;
         end else if (w_vcnt_inc == L_VS_OFF) begin
            r_vsync <= 1'b0;
            r_armed <= 1'b0;
         end else begin
            r_vsync <= r_vsync;
         end
      end else begin
         r_armed <= r_armed;
         r_vcnt  <= r_vcnt;
         r_vsync <= r_vsync;
      end
   end

   // ----------------------------------------------------------------- interrupt
   // Counter-event value for this clock; equals LINE_CNT when nothing happens.
   always_comb begin
      w_cnt_inc = r_line_cnt + 6'd1;
      w_cnt_ev  = r_line_cnt;
      w_int_set = 1'b0;
      if (w_vs_int) begin
         w_cnt_ev  = 6'd0;
         w_int_set = (r_line_cnt >= GA_INT_VS_THRESH);
      end else if (w_hs_fall) begin
         if (w_cnt_inc == GA_INT_LINES) begin
            w_cnt_ev  = 6'd0;
            w_int_set = 1'b1;
         end else begin
            w_cnt_ev  = w_cnt_inc;
         end
      end else begin
         w_cnt_ev  = r_line_cnt;
      end
   end

   // Interrupt state: clear > counter-set > acknowledge (ack also drops bit 5).
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_int      <= 1'b0;
         r_line_cnt <= 6'd0;
      end else if (INT_CLR) begin
         r_int      <= 1'b0;
         r_line_cnt <= 6'd0;
      end else if (w_int_set) begin
         r_int      <= 1'b1;
         r_line_cnt <= w_cnt_ev;
      end else if (INT_ACK) begin
         r_int      <= 1'b0;
         r_line_cnt <= {1'b0, w_cnt_ev[4:0]};
      end else begin
         r_int      <= r_int;
         r_line_cnt <= w_cnt_ev;
      end
   end

   // ---------------------------------------------------------------------- mode
`ifdef GA_MODE_LATCH_EN
   ga_mode_t r_mode;
   logic     w_hsync_up;

   assign w_hsync_up = w_hs_on & ~w_hs_off & ~r_hsync;

   // Capture the mode as the monitor line starts so changes apply next line.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_mode <= MODE0;
      end else if (w_hsync_up) begin
         r_mode <= ga_mode_t'(MODE_IN);
      end else begin
         r_mode <= r_mode;
      end
   end

   assign MODE = r_mode;
`else
   assign MODE = MODE_IN;
`endif

   assign HSYNC    = r_hsync;
   assign VSYNC    = r_vsync;
   assign INT      = r_int;
   assign LINE_CNT = r_line_cnt;

endmodule

// File: tb/tb_ga_sync.sv
// -----------------------------------------------------------------------------
// tb_ga_sync
// Directed bench for ga_sync with hand-computed expectations. One character
// tick = one CLKEN clock followed by one idle clock. Inputs change and outputs
// are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_ga_sync;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic       CLKEN = 1'b0;
   logic       CRTC_HSYNC = 1'b0;
   logic       CRTC_VSYNC = 1'b0;
   logic       INT_ACK = 1'b0;
   logic       INT_CLR = 1'b0;
   logic [1:0] MODE_IN = 2'd0;
   logic       HSYNC;
   logic       VSYNC;
   logic       INT;
   logic [1:0] MODE;
   logic [5:0] LINE_CNT;

   int n_checks = 0;
   int n_errors = 0;

   ga_sync dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .CLKEN      (CLKEN),
      .CRTC_HSYNC (CRTC_HSYNC),
      .CRTC_VSYNC (CRTC_VSYNC),
      .INT_ACK    (INT_ACK),
      .INT_CLR    (INT_CLR),
      .MODE_IN    (MODE_IN),
      .HSYNC      (HSYNC),
      .VSYNC      (VSYNC),
      .INT        (INT),
      .MODE       (MODE),
      .LINE_CNT   (LINE_CNT)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // One character tick; single-clock strobes are dropped after the CLKEN clock.
   task automatic do_tick();
      CLKEN = 1'b1;
      @(posedge CLOCK); #1;
      CLKEN   = 1'b0;
      INT_CLR = 1'b0;
      INT_ACK = 1'b0;
      @(posedge CLOCK); #1;
   endtask

   // Short CRTC line (2 ticks high, 1 low): one hs_fall, no monitor HSYNC.
   task automatic hs_line(input int n);
      for (int k = 0; k < n; k++) begin
         CRTC_HSYNC = 1'b1;
         do_tick();
         do_tick();
         CRTC_HSYNC = 1'b0;
         do_tick();
      end
   endtask

   // CRTC pulse of len ticks, checking HSYNC after each tick and after the fall.
   task automatic hs_pulse(input int len, input string tag);
      CRTC_HSYNC = 1'b1;
      for (int k = 0; k < len; k++) begin
         do_tick();
         chk(tag, HSYNC, (k >= 2 && k <= 5) ? 1 : 0);
      end
      CRTC_HSYNC = 1'b0;
      do_tick();
      chk({tag, "_fall"}, HSYNC, 0);
   endtask

   task automatic pulse_ack();
      INT_ACK = 1'b1;
      @(posedge CLOCK); #1;
      INT_ACK = 1'b0;
   endtask

   task automatic pulse_clr();
      INT_CLR = 1'b1;
      @(posedge CLOCK); #1;
      INT_CLR = 1'b0;
   endtask

   initial begin
      int mode_exp;

      repeat (2) @(posedge CLOCK);
      #1 RESET = 1'b0;
      chk("rst_hsync", HSYNC, 0);
      chk("rst_vsync", VSYNC, 0);
      chk("rst_int", INT, 0);
      chk("rst_line", LINE_CNT, 0);

      // Long, medium and too-short CRTC pulses.
      hs_pulse(14, "hs_long");
      chk("line_after_long", LINE_CNT, 1);
      hs_pulse(4, "hs_cut");
      hs_pulse(2, "hs_short");
      chk("line_after_3", LINE_CNT, 3);

      // 52-line interrupt and acknowledge.
      RESET = 1'b1;
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      chk("line_rst", LINE_CNT, 0);
      hs_line(51);
      chk("line_51", LINE_CNT, 51);
      chk("int_51", INT, 0);
      hs_line(1);
      chk("int_52", INT, 1);
      chk("line_52", LINE_CNT, 0);
      pulse_ack();
      chk("int_ack", INT, 0);
      chk("line_ack0", LINE_CNT, 0);

      // VSYNC with LINE_CNT at 40: interrupt at the 2nd hs_fall.
      hs_line(40);
      chk("line_40", LINE_CNT, 40);
      CRTC_VSYNC = 1'b1;
      do_tick();
      hs_line(1);
      chk("vs_wait", VSYNC, 0);
      chk("vs_wait_line", LINE_CNT, 41);
      hs_line(1);
      chk("vs_on", VSYNC, 1);
      chk("vs_int40", INT, 1);
      chk("vs_line40", LINE_CNT, 0);
      hs_line(3);
      chk("vs_hold", VSYNC, 1);
      hs_line(1);
      chk("vs_width_end", VSYNC, 0);
      chk("vs_width_line", LINE_CNT, 4);
      CRTC_VSYNC = 1'b0;
      do_tick();
      pulse_ack();
      chk("int_ack2", INT, 0);
      chk("line_ack4", LINE_CNT, 4);

      // VSYNC with LINE_CNT at 20: no interrupt; early clear on CRTC low.
      hs_line(16);
      chk("line_20", LINE_CNT, 20);
      CRTC_VSYNC = 1'b1;
      do_tick();
      hs_line(2);
      chk("vs_on20", VSYNC, 1);
      chk("vs_int20", INT, 0);
      chk("vs_line20", LINE_CNT, 0);
      CRTC_VSYNC = 1'b0;
      do_tick();
      chk("vs_early_off", VSYNC, 0);

      // Acknowledge without pending interrupt clears bit 5 only.
      hs_line(45);
      chk("line_45", LINE_CNT, 45);
      pulse_ack();
      chk("ack_line13", LINE_CNT, 13);
      chk("ack_int13", INT, 0);

      // INT_CLR on the 52nd fall beats the interrupt set.
      hs_line(38);
      chk("line_51b", LINE_CNT, 51);
      CRTC_HSYNC = 1'b1;
      do_tick();
      do_tick();
      CRTC_HSYNC = 1'b0;
      INT_CLR = 1'b1;
      do_tick();
      chk("clr52_int", INT, 0);
      chk("clr52_line", LINE_CNT, 0);

      // INT_ACK on the 52nd fall loses to the interrupt set.
      hs_line(51);
      CRTC_HSYNC = 1'b1;
      do_tick();
      do_tick();
      CRTC_HSYNC = 1'b0;
      INT_ACK = 1'b1;
      do_tick();
      chk("ack52_int", INT, 1);
      chk("ack52_line", LINE_CNT, 0);
      pulse_clr();
      chk("clr_int", INT, 0);

      // Reset during active HSYNC and VSYNC.
      MODE_IN = 2'd3;
      CRTC_VSYNC = 1'b1;
      do_tick();
      hs_line(2);
      CRTC_HSYNC = 1'b1;
      do_tick();
      do_tick();
      do_tick();
      chk("pre_rst_hsync", HSYNC, 1);
      chk("pre_rst_vsync", VSYNC, 1);
      chk("mode_line", MODE, 3);
      MODE_IN = 2'd1;
`ifdef GA_MODE_LATCH_EN
      mode_exp = 3;
`else
      mode_exp = 1;
`endif
      chk("mode_midline", MODE, mode_exp);
      RESET = 1'b1;
      CRTC_HSYNC = 1'b0;
      CRTC_VSYNC = 1'b0;
      @(posedge CLOCK); #1;
      RESET = 1'b0;
`ifdef GA_MODE_LATCH_EN
      mode_exp = 0;
`else
      mode_exp = 1;
`endif
      chk("rst2_hsync", HSYNC, 0);
      chk("rst2_vsync", VSYNC, 0);
      chk("rst2_line", LINE_CNT, 0);
      chk("rst2_int", INT, 0);
      chk("rst2_mode", MODE, mode_exp);

      // Next full pulse after reset behaves normally.
      hs_pulse(14, "hs_post_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
